wb_commit_ctrl: RTL and testbench
=================================

Name: wb_commit_ctrl

Overview:
- Commit sequencer that sits between the MEM_WB pipeline register and the architectural-state write ports of the dual-issue core: the register file (2 write ports), the CSR file (1 write port) and the exception/flush interface.
- Enforces in-order commit and exception priority between line1 (older) and line2 (younger).
- Serialises a same-bundle double CSR write over two cycles by back-pressuring MEM_WB.
- Maintains a 64-bit retired-instruction counter.

Parameters:
DATA_W, 32, regfile/CSR data width and PC width
REG_AW, 5, regfile address width
CSR_AW, 14, CSR number width
ECODE_W, 6, exception code width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lineN_valid_i  in  1  (N=1,2) MEM_WB slot valid
lineN_excep_i  in  1  slot carries exception
lineN_ecode_i  in  ECODE_W  exception code
lineN_pc_i  in  DATA_W  slot PC
lineN_rf_we_i  in  1  regfile write request
lineN_rf_waddr_i  in  REG_AW  regfile write address
lineN_rf_wdata_i  in  DATA_W  regfile write data
lineN_csr_we_i  in  1  CSR write request
lineN_csr_waddr_i  in  CSR_AW  CSR number
lineN_csr_wdata_i  in  DATA_W  CSR write data
now_allowin_o  out  1  MEM_WB may load a new bundle
rfN_we_o  out  1  regfile port N write enable
rfN_waddr_o  out  REG_AW  regfile port N address
rfN_wdata_o  out  DATA_W  regfile port N data
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  CSR_AW  CSR number
csr_wdata_o  out  DATA_W  CSR data
excep_flush_o  out  1  pipeline flush, asserted in the exception commit cycle
excep_ecode_o  out  ECODE_W  code of the committed exception, 0 when none
excep_pc_o  out  DATA_W  PC of the excepting instruction, 0 when none
retired_cnt_o  out  64  retired-instruction count

Behaviour:
- Reset is asynchronous and active-low.
  - state=IDLE, retired_cnt=0.
  - With valids low, every output is 0 except now_allowin_o=1.
- State machine: IDLE, SECOND. Outputs are combinational from state and inputs; only state and the counter are registered.
- Definitions:
  - k1 = line1_valid_i & line1_excep_i
  - k2 = line2_valid_i & line2_excep_i & ~k1 (line2 is killed when k1)
  - conflict = line1_valid_i & line2_valid_i & line1_csr_we_i & line2_csr_we_i & ~line1_excep_i
- IDLE, conflict=0 (single cycle):
  - rf1/csr driven from line1 when line1 valid and ~line1_excep.
  - rf2 driven from line2 when line2 valid, ~line2_excep, ~k1.
  - CSR port carries whichever single line writes it.
  - excep_flush_o = k1|k2; ecode/pc taken from line1 if k1, else line2.
  - now_allowin_o=1.
- IDLE, conflict=1: commit line1 only (rf1, CSR from line1). rf2_we_o=0, now_allowin_o=0, next state SECOND.
- SECOND: inputs are held stable by MEM_WB because allowin was low.
  - Commit line2: rf2 and CSR from line2 unless line2_excep, in which case flush with line2 ecode/pc.
  - rf1_we_o=0, now_allowin_o=1, next state IDLE.
- Exceptions:
  - An excepting instruction writes neither regfile nor CSR.
  - At most one exception per cycle, and line1 always has priority.
- Address-0 writes are passed through unmodified; the regfile ignores them.
- If both regfile ports target the same address in one cycle, rf2 has priority. This is the regfile's rule, not enforced here.
- retired_cnt increments each cycle by the number of instructions whose commit completes that cycle:
  - IDLE no-conflict: count of valid, non-killed, non-excepting lines (0..2).
  - Conflict first cycle: +1.
  - SECOND: +1 unless line2_excep.
  - Excepting instructions are not counted.
  - The 64-bit counter wraps modulo 2^64.
- excep_flush_o in SECOND does not abort the line1 commit already done in the previous cycle.
- Reset asserted in SECOND returns to IDLE immediately; the line2 commit is lost, and that is acceptable because the pipeline is also reset.

Test Plan:
- Both valid, line1 rf_we to r4=0x11, line2 rf_we to r5=0x22, no CSR -> same cycle rf1/rf2 writes, allowin=1, retired_cnt 0->2.
- Both valid with csr_we (line1 CSR 0x0 data 0xA, line2 CSR 0x5 data 0xB):
  - cycle0: csr 0x0/0xA, allowin=0.
  - cycle1: csr 0x5/0xB, allowin=1.
  - counter +1 in each cycle; state returns to IDLE.
- line1_excep ecode=0x0B pc=0x1C000100, line2 valid with rf_we -> flush=1, ecode=0x0B, pc=0x1C000100, no rf/csr writes, counter unchanged.
- line1 normal rf_we r3, line2_excep ecode=0x08 pc=0x1C000204 -> rf1 writes r3, rf2_we=0, flush with line2 ecode/pc, counter +1.
- Conflict where line2_excep=1 -> cycle0 line1 CSR write, allowin=0; cycle1 flush with line2 ecode, csr_we=0; counter +1 total.
- Assert rst_n low while in SECOND -> next observation: IDLE, allowin=1, all write enables 0, retired_cnt=0; preload counter to 2^64-1 then commit 1 instruction -> wraps to 0.

Source files
------------

// File: rtl/wb_commit_ctrl.sv
// Commit sequencer between the MEM_WB register and the architectural write
// ports. It commits up to two instructions per cycle in program order.
// line1 is the older instruction and wins any exception priority.
// When both lines of one bundle write a CSR, the two writes are split over
// two cycles: MEM_WB is stalled for one cycle while line2 is still pending.
// It also keeps the 64-bit retired-instruction counter.
module wb_commit_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int CSR_AW  = 14,
    parameter int ECODE_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line1_valid_i,
    input  logic               line1_excep_i,
    input  logic [ECODE_W-1:0] line1_ecode_i,
    input  logic [DATA_W-1:0]  line1_pc_i,
    input  logic               line1_rf_we_i,
    input  logic [REG_AW-1:0]  line1_rf_waddr_i,
    input  logic [DATA_W-1:0]  line1_rf_wdata_i,
    input  logic               line1_csr_we_i,
    input  logic [CSR_AW-1:0]  line1_csr_waddr_i,
    input  logic [DATA_W-1:0]  line1_csr_wdata_i,
    input  logic               line2_valid_i,
    input  logic               line2_excep_i,
    input  logic [ECODE_W-1:0] line2_ecode_i,
    input  logic [DATA_W-1:0]  line2_pc_i,
    input  logic               line2_rf_we_i,
    input  logic [REG_AW-1:0]  line2_rf_waddr_i,
    input  logic [DATA_W-1:0]  line2_rf_wdata_i,
    input  logic               line2_csr_we_i,
    input  logic [CSR_AW-1:0]  line2_csr_waddr_i,
    input  logic [DATA_W-1:0]  line2_csr_wdata_i,
    output logic               now_allowin_o,
    output logic               rf1_we_o,
    output logic [REG_AW-1:0]  rf1_waddr_o,
    output logic [DATA_W-1:0]  rf1_wdata_o,
    output logic               rf2_we_o,
    output logic [REG_AW-1:0]  rf2_waddr_o,
    output logic [DATA_W-1:0]  rf2_wdata_o,
    output logic               csr_we_o,
    output logic [CSR_AW-1:0]  csr_waddr_o,
    output logic [DATA_W-1:0]  csr_wdata_o,
    output logic               excep_flush_o,
    output logic [ECODE_W-1:0] excep_ecode_o,
    output logic [DATA_W-1:0]  excep_pc_o,
    output logic [63:0]        retired_cnt_o
);

    // SECOND means line1 of a double-CSR bundle has already committed.
    // line2 of that bundle is still waiting to commit.
    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] retired_cnt_q;
    logic [1:0]  retire_inc;

    logic k1;
    logic k2;
    logic conflict;
    logic commit1;
    logic commit2;

    // An excepting line1 kills line2.
    // A CSR conflict only exists if line1 is really going to write.
    assign k1       = line1_valid_i & line1_excep_i;
    assign k2       = line2_valid_i & line2_excep_i & ~k1;
    assign conflict = line1_valid_i & line2_valid_i & line1_csr_we_i &
                      line2_csr_we_i & ~line1_excep_i;
    assign commit1  = line1_valid_i & ~line1_excep_i;
    assign commit2  = line2_valid_i & ~line2_excep_i & ~k1;

    // State register for the CSR-split sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and the commit port drive, all decoded from the state and the current bundle
    always_comb begin
        state_nxt     = state;
        now_allowin_o = 1'b1;
        rf1_we_o      = 1'b0;
        rf1_waddr_o   = '0;
        rf1_wdata_o   = '0;
        rf2_we_o      = 1'b0;
        rf2_waddr_o   = '0;
        rf2_wdata_o   = '0;
        csr_we_o      = 1'b0;
        csr_waddr_o   = '0;
        csr_wdata_o   = '0;
        excep_flush_o = 1'b0;
        excep_ecode_o = '0;
        excep_pc_o    = '0;
        retire_inc    = 2'd0;

        case (state)
            IDLE: begin
                if (conflict) begin
                    // Commit line1 only. Hold MEM_WB so that line2 stays
                    // stable for the next cycle.
                    if (line1_rf_we_i) begin
                        rf1_we_o    = 1'b1;
                        rf1_waddr_o = line1_rf_waddr_i;
                        rf1_wdata_o = line1_rf_wdata_i;
                    end
                    csr_we_o      = 1'b1;
                    csr_waddr_o   = line1_csr_waddr_i;
                    csr_wdata_o   = line1_csr_wdata_i;
                    now_allowin_o = 1'b0;
                    retire_inc    = 2'd1;
                    state_nxt     = SECOND;
                end else begin
                    if (commit1 && line1_rf_we_i) begin
                        rf1_we_o    = 1'b1;
                        rf1_waddr_o = line1_rf_waddr_i;
                        rf1_wdata_o = line1_rf_wdata_i;
                    end
                    if (commit2 && line2_rf_we_i) begin
                        rf2_we_o    = 1'b1;
                        rf2_waddr_o = line2_rf_waddr_i;
                        rf2_wdata_o = line2_rf_wdata_i;
                    end
                    // Without a conflict, at most one committing line writes the CSR.
                    if (commit1 && line1_csr_we_i) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = line1_csr_waddr_i;
                        csr_wdata_o = line1_csr_wdata_i;
                    end else if (commit2 && line2_csr_we_i) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = line2_csr_waddr_i;
                        csr_wdata_o = line2_csr_wdata_i;
                    end
                    if (k1) begin
                        excep_flush_o = 1'b1;
                        excep_ecode_o = line1_ecode_i;
                        excep_pc_o    = line1_pc_i;
                    end else if (k2) begin
                        excep_flush_o = 1'b1;
                        excep_ecode_o = line2_ecode_i;
                        excep_pc_o    = line2_pc_i;
                    end
                    retire_inc = {1'b0, commit1} + {1'b0, commit2};
                end
            end

            SECOND: begin
                // line2 of the stalled bundle. line1 committed in the
                // previous cycle, so a flush here does not undo line1.
                if (line2_excep_i) begin
                    excep_flush_o = line2_valid_i;
                    excep_ecode_o = line2_valid_i ? line2_ecode_i : '0;
                    excep_pc_o    = line2_valid_i ? line2_pc_i : '0;
                end else if (line2_valid_i) begin
                    if (line2_rf_we_i) begin
                        rf2_we_o    = 1'b1;
                        rf2_waddr_o = line2_rf_waddr_i;
                        rf2_wdata_o = line2_rf_wdata_i;
                    end
                    if (line2_csr_we_i) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = line2_csr_waddr_i;
                        csr_wdata_o = line2_csr_wdata_i;
                    end
                    retire_inc = 2'd1;
                end
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Retired-instruction counter, wrapping modulo 2^64
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_q + {62'd0, retire_inc};
        end
    end

    assign retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Bench for wb_commit_ctrl: directed scenarios followed by random bundles.
// Each bundle is scored against a bundle-level model of the commit rules.
module tb_wb_commit_ctrl;

    typedef struct {
        logic        v;
        logic        ex;
        logic [5:0]  ec;
        logic [31:0] pc;
        logic        rwe;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic        cwe;
        logic [13:0] ca;
        logic [31:0] cd;
    } line_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line1_valid, line1_excep, line1_rf_we, line1_csr_we;
    logic [5:0]  line1_ecode;
    logic [31:0] line1_pc, line1_rf_wdata, line1_csr_wdata;
    logic [4:0]  line1_rf_waddr;
    logic [13:0] line1_csr_waddr;
    logic        line2_valid, line2_excep, line2_rf_we, line2_csr_we;
    logic [5:0]  line2_ecode;
    logic [31:0] line2_pc, line2_rf_wdata, line2_csr_wdata;
    logic [4:0]  line2_rf_waddr;
    logic [13:0] line2_csr_waddr;
    logic        now_allowin, rf1_we, rf2_we, csr_we, excep_flush;
    logic [4:0]  rf1_waddr, rf2_waddr;
    logic [31:0] rf1_wdata, rf2_wdata, csr_wdata, excep_pc;
    logic [13:0] csr_waddr;
    logic [5:0]  excep_ecode;
    logic [63:0] retired_cnt;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] cnt_exp  = 64'd0;

    always #5 clk = ~clk;

    wb_commit_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .line1_valid_i(line1_valid), .line1_excep_i(line1_excep), .line1_ecode_i(line1_ecode),
        .line1_pc_i(line1_pc), .line1_rf_we_i(line1_rf_we), .line1_rf_waddr_i(line1_rf_waddr),
        .line1_rf_wdata_i(line1_rf_wdata), .line1_csr_we_i(line1_csr_we),
        .line1_csr_waddr_i(line1_csr_waddr), .line1_csr_wdata_i(line1_csr_wdata),
        .line2_valid_i(line2_valid), .line2_excep_i(line2_excep), .line2_ecode_i(line2_ecode),
        .line2_pc_i(line2_pc), .line2_rf_we_i(line2_rf_we), .line2_rf_waddr_i(line2_rf_waddr),
        .line2_rf_wdata_i(line2_rf_wdata), .line2_csr_we_i(line2_csr_we),
        .line2_csr_waddr_i(line2_csr_waddr), .line2_csr_wdata_i(line2_csr_wdata),
        .now_allowin_o(now_allowin),
        .rf1_we_o(rf1_we), .rf1_waddr_o(rf1_waddr), .rf1_wdata_o(rf1_wdata),
        .rf2_we_o(rf2_we), .rf2_waddr_o(rf2_waddr), .rf2_wdata_o(rf2_wdata),
        .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
        .excep_flush_o(excep_flush), .excep_ecode_o(excep_ecode), .excep_pc_o(excep_pc),
        .retired_cnt_o(retired_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input line_t a, input line_t b);
        line1_valid = a.v; line1_excep = a.ex; line1_ecode = a.ec; line1_pc = a.pc;
        line1_rf_we = a.rwe; line1_rf_waddr = a.ra; line1_rf_wdata = a.rd;
        line1_csr_we = a.cwe; line1_csr_waddr = a.ca; line1_csr_wdata = a.cd;
        line2_valid = b.v; line2_excep = b.ex; line2_ecode = b.ec; line2_pc = b.pc;
        line2_rf_we = b.rwe; line2_rf_waddr = b.ra; line2_rf_wdata = b.rd;
        line2_csr_we = b.cwe; line2_csr_waddr = b.ca; line2_csr_wdata = b.cd;
    endtask

    function automatic line_t idle_line();
        line_t l;
        l.v = 0; l.ex = 0; l.ec = 0; l.pc = 0; l.rwe = 0; l.ra = 0; l.rd = 0;
        l.cwe = 0; l.ca = 0; l.cd = 0;
        return l;
    endfunction

    function automatic line_t mk(input logic v, input logic ex, input logic [5:0] ec,
                                 input logic [31:0] pc, input logic rwe, input logic [4:0] ra,
                                 input logic [31:0] rd, input logic cwe, input logic [13:0] ca,
                                 input logic [31:0] cd);
        line_t l;
        l.v = v; l.ex = ex; l.ec = ec; l.pc = pc; l.rwe = rwe; l.ra = ra; l.rd = rd;
        l.cwe = cwe; l.ca = ca; l.cd = cd;
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        l.v   = ($urandom_range(0, 4) != 0);
        l.ex  = ($urandom_range(0, 3) == 0);
        l.ec  = 6'($urandom);
        l.pc  = $urandom;
        l.rwe = $urandom_range(0, 1) == 1;
        l.ra  = 5'($urandom);
        l.rd  = $urandom;
        l.cwe = $urandom_range(0, 1) == 1;
        l.ca  = 14'($urandom);
        l.cd  = $urandom;
        return l;
    endfunction

    // Compare every output against one expected commit cycle.
    // Inputs are expected to be held stable until the following clock edge.
    task automatic check_cycle(input string tag, input logic allow,
                               input logic w1, input line_t s1,
                               input logic w2, input line_t s2,
                               input logic wc, input line_t sc,
                               input logic fl, input line_t se, input int inc);
        @(negedge clk);
        chk({tag, ".allowin"}, 64'(now_allowin), 64'(allow));
        chk({tag, ".rf1_we"}, 64'(rf1_we), 64'(w1));
        chk({tag, ".rf1_addr"}, 64'(rf1_waddr), w1 ? 64'(s1.ra) : 64'd0);
        chk({tag, ".rf1_data"}, 64'(rf1_wdata), w1 ? 64'(s1.rd) : 64'd0);
        chk({tag, ".rf2_we"}, 64'(rf2_we), 64'(w2));
        chk({tag, ".rf2_addr"}, 64'(rf2_waddr), w2 ? 64'(s2.ra) : 64'd0);
        chk({tag, ".rf2_data"}, 64'(rf2_wdata), w2 ? 64'(s2.rd) : 64'd0);
        chk({tag, ".csr_we"}, 64'(csr_we), 64'(wc));
        chk({tag, ".csr_addr"}, 64'(csr_waddr), wc ? 64'(sc.ca) : 64'd0);
        chk({tag, ".csr_data"}, 64'(csr_wdata), wc ? 64'(sc.cd) : 64'd0);
        chk({tag, ".flush"}, 64'(excep_flush), 64'(fl));
        chk({tag, ".ecode"}, 64'(excep_ecode), fl ? 64'(se.ec) : 64'd0);
        chk({tag, ".epc"}, 64'(excep_pc), fl ? 64'(se.pc) : 64'd0);
        @(posedge clk);
        #1;
        cnt_exp = cnt_exp + 64'(inc);
        chk({tag, ".retired"}, retired_cnt, cnt_exp);
    endtask

    // Commit one bundle and score it. A double CSR write takes two cycles,
    // otherwise the bundle finishes in one cycle.
    task automatic run_bundle(input string tag, input line_t a, input line_t b);
        logic  dead2, live1, live2, split;
        line_t none;
        none  = idle_line();
        drive(a, b);
        live1 = a.v && !a.ex;
        dead2 = a.v && a.ex;
        live2 = b.v && !b.ex && !dead2;
        split = live1 && b.v && a.cwe && b.cwe;
        if (!split) begin
            check_cycle(tag, 1'b1,
                        live1 && a.rwe, a, live2 && b.rwe, b,
                        (live1 && a.cwe) || (live2 && b.cwe), (live1 && a.cwe) ? a : b,
                        dead2 || (b.v && b.ex), dead2 ? a : b,
                        int'(live1) + int'(live2));
        end else begin
            check_cycle({tag, ".c0"}, 1'b0, a.rwe, a, 1'b0, none, 1'b1, a, 1'b0, none, 1);
            check_cycle({tag, ".c1"}, 1'b1, 1'b0, none, !b.ex && b.rwe, b,
                        !b.ex, b, b.ex, b, b.ex ? 0 : 1);
        end
    endtask

    initial begin
        line_t z;
        z = idle_line();
        rst_n = 1'b0;
        drive(z, z);
        #12;
        chk("reset.allowin", 64'(now_allowin), 64'd1);
        chk("reset.we", 64'({rf1_we, rf2_we, csr_we, excep_flush}), 64'd0);
        chk("reset.data", 64'(rf1_wdata | rf2_wdata | csr_wdata | excep_pc), 64'd0);
        chk("reset.cnt", retired_cnt, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_bundle("dual_rf",
                   mk(1, 0, 0, 32'h100, 1, 5'd4, 32'h11, 0, 0, 0),
                   mk(1, 0, 0, 32'h104, 1, 5'd5, 32'h22, 0, 0, 0));
        run_bundle("csr_split",
                   mk(1, 0, 0, 32'h200, 0, 0, 0, 1, 14'h0, 32'hA),
                   mk(1, 0, 0, 32'h204, 0, 0, 0, 1, 14'h5, 32'hB));
        run_bundle("l1_excep",
                   mk(1, 1, 6'h0B, 32'h1C000100, 1, 5'd7, 32'h77, 1, 14'h3, 32'h3),
                   mk(1, 0, 0, 32'h1C000104, 1, 5'd8, 32'h88, 0, 0, 0));
        run_bundle("l2_excep",
                   mk(1, 0, 0, 32'h1C000200, 1, 5'd3, 32'h33, 0, 0, 0),
                   mk(1, 1, 6'h08, 32'h1C000204, 1, 5'd9, 32'h99, 0, 0, 0));
        run_bundle("split_l2_excep",
                   mk(1, 0, 0, 32'h300, 1, 5'd0, 32'h5, 1, 14'h10, 32'hC),
                   mk(1, 1, 6'h11, 32'h304, 1, 5'd1, 32'h6, 1, 14'h11, 32'hD));
        run_bundle("idle", z, z);

        // Reset asserted while the split is in its SECOND cycle.
        drive(mk(1, 0, 0, 32'h400, 0, 0, 0, 1, 14'h1, 32'h1),
              mk(1, 0, 0, 32'h404, 0, 0, 0, 1, 14'h2, 32'h2));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(z, z);
        #1;
        cnt_exp = 64'd0;
        chk("rst_second.allowin", 64'(now_allowin), 64'd1);
        chk("rst_second.we", 64'({rf1_we, rf2_we, csr_we, excep_flush}), 64'd0);
        chk("rst_second.cnt", retired_cnt, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_bundle("after_rst", mk(1, 0, 0, 32'h500, 1, 5'd2, 32'h2, 0, 0, 0), z);

        // Counter wrap: load all ones, then retire exactly one instruction.
        force dut.retired_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retired_cnt_q;
        cnt_exp = 64'hFFFF_FFFF_FFFF_FFFF;
        run_bundle("wrap", z, mk(1, 0, 0, 32'h600, 1, 5'd6, 32'h6, 0, 0, 0));

        for (int i = 0; i < 200; i++) begin
            run_bundle("rand", rand_line(), rand_line());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
